// File: rtl/ifu_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned IFU_ADDR_W  = 16;
    localparam int unsigned IFU_INSTR_W = 16;
    localparam int unsigned IFU_OPC_W   = 5;

    // Opcode field encoding of instr[4:0], as seen by the downstream decoder.
    typedef enum logic [IFU_OPC_W-1:0] {
        OP_MV   = 5'b00000,
        OP_ADD  = 5'b00001,
        OP_SUB  = 5'b00010,
        OP_CMP  = 5'b00011,
        OP_LD   = 5'b00100,
        OP_ST   = 5'b00101,
        OP_MVI  = 5'b10000,
        OP_ADDI = 5'b10001,
        OP_SUBI = 5'b10010,
        OP_CMPI = 5'b10011,
        OP_MVHI = 5'b10110,
        OP_JR   = 5'b01000,
        OP_JZR  = 5'b01001,
        OP_JNR  = 5'b01010,
        OP_J    = 5'b11000,
        OP_JZ   = 5'b11001,
        OP_JN   = 5'b11010
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } ifu_state_t;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [IFU_ADDR_W-1:0]  pc;
        logic [IFU_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous prefetch FIFO of fetch entries with flush.
// Flush wins over push/pop; a push into a full FIFO is accepted only together with a pop.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order reads on the shared
// memory port, buffers returned words and hands them to the decoder.
// Optional IFU_BYPASS_EN: a response arriving at an empty FIFO is presented to the
// decoder in the same cycle instead of one cycle later.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = IFU_ADDR_W,
    parameter int unsigned       INSTR_W   = IFU_INSTR_W,
    parameter int unsigned       BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               instr_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus2
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W-1:0]  drop_on_redirect;
    logic              accept, rsp_keep, drop_dec, bypass_c;
    logic              fifo_push, fifo_pop, fifo_empty;
    logic [ADDR_W-1:0] rsp_pc;
    fetch_entry_t      push_entry, fifo_head, head_entry;

    // Response bookkeeping: the oldest outstanding read is 2*outstanding behind fetch_pc.
    always_comb begin
        accept      = imem_req && imem_gnt;
        rsp_keep    = imem_rvalid && (drop_q == '0) && (outst_q != '0);
        drop_dec    = imem_rvalid && (drop_q != '0);
        rsp_pc      = fetch_pc_q - (ADDR_W'(outst_q) << 1);
        credit_used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(outst_q);
        push_entry  = '{pc: rsp_pc, instr: imem_rdata};
        drop_on_redirect = outst_q - CNT_W'(rsp_keep);
    end

`ifdef IFU_BYPASS_EN
    assign bypass_c = rsp_keep && fifo_empty;
`else
    assign bypass_c = 1'b0;
`endif

    // Decoder-facing head selection and FIFO control.
    always_comb begin
        head_entry  = bypass_c ? push_entry : fifo_head;
        instr_valid = !fifo_empty || bypass_c;
        fifo_pop    = !fifo_empty && instr_ready;
        fifo_push   = rsp_keep && !(bypass_c && instr_ready);
    end

    // Fetch FSM next-state, request generation and counters; redirect has top priority.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(rsp_keep);
        drop_d     = drop_q - CNT_W'(drop_dec);
        imem_req   = 1'b0;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   imem_req = !redirect && (credit_used < (CNT_W + 1)'(BUF_DEPTH));
            DRAIN:   if (drop_q == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(2);
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if (state_q != DRAIN) begin
                drop_d  = drop_on_redirect;
                outst_d = '0;
                state_d = (drop_on_redirect != '0) ? DRAIN : FETCH;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    ifu_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign imem_addr = fetch_pc_q;
    assign instr     = head_entry.instr;
    assign opcode    = head_entry.instr[4:0];
    assign instr_pc  = head_entry.pc;
    assign pc_plus2  = head_entry.pc + ADDR_W'(2);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order fixed-latency memory model.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk, reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [15:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_ready, instr_valid;
    logic [15:0] instr, instr_pc, pc_plus2;
    logic [4:0]  opcode;

    instr_fetch_unit #(
        .ADDR_W    (16),
        .INSTR_W   (16),
        .BUF_DEPTH (2),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .pc_plus2    (pc_plus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h0021 ^ 16'(a[5:1]);
    endfunction

    // Memory model: request accepted in cycle t returns data in cycle t+lat.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  cnt;
    } rsp_t;
    rsp_t        mq[$];
    int unsigned lat = 1;

    initial begin
        logic        acc;
        logic [15:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0;
        forever begin
            @(negedge clk);
            acc = imem_req && imem_gnt && !reset;
            a   = imem_addr;
            @(posedge clk);
            #1;
            if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
            foreach (mq[i]) mq[i].cnt = mq[i].cnt - 8'd1;
            if (acc) mq.push_back('{addr: a, cnt: 8'(lat)});
            if (mq.size() > 0 && mq[0].cnt == 8'd1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mq[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 16'h0;
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req"},      32'(imem_req),    32'd0);
        chk({tag, " addr"},     32'(imem_addr),   32'(RESET_PC));
        chk({tag, " valid"},    32'(instr_valid), 32'd0);
        chk({tag, " instr"},    32'(instr),       32'd0);
        chk({tag, " opcode"},   32'(opcode),      32'd0);
        chk({tag, " instr_pc"}, 32'(instr_pc),    32'd0);
        chk({tag, " pc_plus2"}, 32'(pc_plus2),    32'd2);
    endtask

    // Quiesce memory traffic, pulse reset, return at the first cycle after release.
    task automatic do_reset(input int unsigned l);
        imem_gnt    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        go();
        for (int i = 0; i < 40 && mq.size() != 0; i++) go();
        lat   = l;
        reset = 1'b1;
        go();
        smp();
        chk_reset_vals("reset");
        go();
        reset = 1'b0;
    endtask

    typedef struct {
        int unsigned lat;
        logic [15:0] tgt;
        logic [15:0] pc0;
        logic [15:0] pp0;
        logic [15:0] pc1;
        logic [15:0] pp1;
    } redir_vec_t;

    redir_vec_t rv[4];
    logic       found;

    initial begin
        rv[0] = '{3, 16'h0100, 16'h0100, 16'h0102, 16'h0102, 16'h0104};
        rv[1] = '{1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 16'h0002};
        rv[2] = '{2, 16'h0040, 16'h0040, 16'h0042, 16'h0042, 16'h0044};
        rv[3] = '{4, 16'h1230, 16'h1230, 16'h1232, 16'h1232, 16'h1234};

        reset       = 1'b1;
        imem_gnt    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic fetch with L=1, decoder stalled.
        do_reset(1);
        imem_gnt = 1'b1;
        smp(); chk("t1 idle req", 32'(imem_req), 32'd0);
        go(); smp();
        chk("t1 req0", 32'(imem_req), 32'd1);
        chk("t1 addr0", 32'(imem_addr), 32'h0000);
        go(); smp();
        chk("t1 addr1", 32'(imem_addr), 32'h0002);
        chk("t1 valid early", 32'(instr_valid), 32'd0);
        go(); smp();
        chk("t1 valid", 32'(instr_valid), 32'd1);
        chk("t1 instr", 32'(instr), 32'h0021);
        chk("t1 opcode", 32'(opcode), 32'h01);
        chk("t1 instr_pc", 32'(instr_pc), 32'h0000);
        chk("t1 pc_plus2", 32'(pc_plus2), 32'h0002);

        // FIFO full with decoder stalled, then drained in order.
        go(); smp();
        chk("t2 req full", 32'(imem_req), 32'd0);
        chk("t2 hold pc", 32'(instr_pc), 32'h0000);
        go(); smp();
        chk("t2 req full2", 32'(imem_req), 32'd0);
        chk("t2 hold valid", 32'(instr_valid), 32'd1);
        go(); instr_ready = 1'b1; smp();
        chk("t2 head0", 32'(instr_pc), 32'h0000);
        go(); imem_gnt = 1'b0; smp();
        chk("t2 head1 pc", 32'(instr_pc), 32'h0002);
        chk("t2 head1 pp2", 32'(pc_plus2), 32'h0004);
        chk("t2 head1 instr", 32'(instr), 32'(mem_word(16'h0002)));
        chk("t2 next req", 32'(imem_req), 32'd1);
        chk("t2 next addr", 32'(imem_addr), 32'h0004);

        // Grant withheld: request and address held.
        for (int i = 0; i < 4; i++) begin
            go(); smp();
            chk("t4 req held", 32'(imem_req), 32'd1);
            chk("t4 addr held", 32'(imem_addr), 32'h0004);
            chk("t4 no data", 32'(instr_valid), 32'd0);
        end
        go(); imem_gnt = 1'b1; smp();
        chk("t4 resume addr", 32'(imem_addr), 32'h0004);
        go(); smp();
        chk("t4 addr6", 32'(imem_addr), 32'h0006);
        chk("t4 valid late", 32'(instr_valid), 32'd0);
        go(); smp();
        chk("t4 valid", 32'(instr_valid), 32'd1);
        chk("t4 pc4", 32'(instr_pc), 32'h0004);
        chk("t4 instr4", 32'(instr), 32'(mem_word(16'h0004)));
        chk("t4 req credit", 32'(imem_req), 32'd0);
        go(); smp();
        chk("t4 pc6", 32'(instr_pc), 32'h0006);
        chk("t4 pp8", 32'(pc_plus2), 32'h0008);
        chk("t4 addr8", 32'(imem_addr), 32'h0008);

        // Redirect scenarios, including drop of in-flight words and PC wrap.
        for (int k = 0; k < 4; k++) begin
            do_reset(rv[k].lat);
            imem_gnt = 1'b1;
            go(); go(); go();
            redirect    = 1'b1;
            redirect_pc = rv[k].tgt;
            smp();
            chk("rd req in redirect", 32'(imem_req), 32'd0);
            go();
            redirect = 1'b0;
            smp();
            chk("rd valid after", 32'(instr_valid), 32'd0);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (imem_req) found = 1'b1;
                else begin go(); smp(); end
            end
            chk("rd req seen", 32'(found), 32'd1);
            chk("rd first addr", 32'(imem_addr), 32'(rv[k].tgt));
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (instr_valid) found = 1'b1;
                else begin go(); smp(); end
            end
            chk("rd valid seen", 32'(found), 32'd1);
            chk("rd pc0", 32'(instr_pc), 32'(rv[k].pc0));
            chk("rd pp0", 32'(pc_plus2), 32'(rv[k].pp0));
            chk("rd instr0", 32'(instr), 32'(mem_word(rv[k].pc0)));
            go(); instr_ready = 1'b1; smp();
            chk("rd pc0 hold", 32'(instr_pc), 32'(rv[k].pc0));
            go(); smp();
            chk("rd valid1", 32'(instr_valid), 32'd1);
            chk("rd pc1", 32'(instr_pc), 32'(rv[k].pc1));
            chk("rd pp1", 32'(pc_plus2), 32'(rv[k].pp1));
        end

        // Reset with two reads in flight; stray responses must be ignored.
        do_reset(4);
        imem_gnt = 1'b1;
        go(); go(); go();
        reset    = 1'b1;
        imem_gnt = 1'b0;
        smp();
        chk_reset_vals("t6 midflight");
        go(); go();
        reset = 1'b0;
        go(); go(); smp();
        chk("t6 stray valid", 32'(instr_valid), 32'd0);
        chk("t6 req", 32'(imem_req), 32'd1);
        chk("t6 addr", 32'(imem_addr), 32'(RESET_PC));
        go(); imem_gnt = 1'b1;
        smp();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) found = 1'b1;
            else begin go(); smp(); end
        end
        chk("t6 valid seen", 32'(found), 32'd1);
        chk("t6 pc", 32'(instr_pc), 32'(RESET_PC));
        chk("t6 instr", 32'(instr), 32'(mem_word(RESET_PC)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end stage of the 16-bit multicycle CPU, directly upstream of the opcode decoder. It owns the PC, issues in-order instruction reads on the shared memory port, and buffers returned words in a small prefetch FIFO. It presents {instr, opcode, instr_pc, pc_plus2} to the decoder with a valid/ready handshake. It yields the port to data accesses (grant-based) and flushes on jump/branch redirect.

Parameters:
ADDR_W, 16, byte address width; PC steps by 2
INSTR_W, 16, instruction width
BUF_DEPTH, 2, prefetch FIFO entries; also the maximum number of outstanding reads
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
imem_req  out  1  read request
imem_addr  out  ADDR_W  read address; equals fetch_pc
imem_gnt  in  1  request accepted this cycle; low while a data ld/st owns the port
imem_rvalid  in  1  read data valid; responses return in order, latency >= 1
imem_rdata  in  INSTR_W  read data
redirect  in  1  PC redirect (taken jump/branch)
redirect_pc  in  ADDR_W  redirect target
instr_ready  in  1  decoder accepts the head instruction; low while the decoder is busy
instr_valid  out  1  head instruction valid
instr  out  INSTR_W  head instruction word
opcode  out  5  instr[4:0]
instr_pc  out  ADDR_W  address of the head instruction
pc_plus2  out  ADDR_W  instr_pc + 2, modulo 2^ADDR_W

Behaviour:
- Reset (asynchronous): state IDLE; fetch_pc = RESET_PC; FIFO count, outstanding and drop counters = 0. imem_req 0, imem_addr RESET_PC, instr_valid 0, instr/opcode/instr_pc 0, pc_plus2 2.
- FSM states:
  - IDLE: no requests; unconditional transition to FETCH after one cycle.
  - FETCH: imem_req = !redirect && (count + outstanding < BUF_DEPTH). Credit is computed from registered values, so a freed slot is not reused in the same cycle.
  - DRAIN: imem_req = 0; go to FETCH when drop == 0.
- Request accepted (imem_req && imem_gnt): outstanding++, fetch_pc += 2 with wrap (16'hFFFE -> 0). If imem_gnt is low, imem_req and imem_addr are held stable.
- imem_rvalid:
  - drop > 0: word discarded, drop--.
  - drop == 0 and outstanding > 0: push {fetch address, word}, outstanding--.
  - drop == 0 and outstanding == 0: stray response, ignored (covers reset mid-flight).
- Consumer handshake: pop when instr_valid && instr_ready. Outputs reflect the FIFO head. Outputs are stable while instr_ready is low.
- Latency (no bypass): request accepted in cycle t, rvalid in t+L, instr_valid in t+L+1.
- Redirect has top priority:
  - Same cycle: a pop of the head still completes; FIFO is cleared; fetch_pc <= redirect_pc.
  - drop <= outstanding remaining after this cycle's rvalid; outstanding <= 0.
  - Next state is DRAIN if drop > 0, else FETCH. A redirect during DRAIN updates fetch_pc only.
  - instr_valid is 0 in the next cycle.
- Full FIFO with simultaneous push and pop is legal; count is unchanged.
- Redirect in IDLE: fetch_pc updated; IDLE -> FETCH as normal.

Optional Feature:
IFU_BYPASS_EN
- Defined: when the FIFO is empty, drop == 0 and rvalid arrives, the word is presented combinationally in the same cycle (instr_valid = 1). If instr_ready is high it is consumed without a push, otherwise it is pushed. Fetch-to-decode latency is L.
- Undefined: no bypass; latency is L+1 as above.

Decomposition:
- ifu_pkg: ADDR_W/INSTR_W defaults; opcode_t enum (OP_MV 00000, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST, OP_MVI 10000, OP_ADDI, OP_SUBI, OP_CMPI, OP_MVHI 10110, OP_JR 01000, OP_JZR, OP_JNR, OP_J 11000, OP_JZ, OP_JN); ifu_state_t {IDLE, FETCH, DRAIN}; fetch_entry_t struct {pc, instr}.
- Sub-module ifu_fifo: BUF_DEPTH-entry synchronous FIFO of fetch_entry_t with flush, push, pop, count.

Test Plan:
1. Release reset, gnt=1, L=1, mem[0]=16'h0021: addresses 0 then 2 issued; instr_valid 3 cycles after reset release with opcode 00001, instr_pc 0, pc_plus2 2.
2. instr_ready=0: after 2 responses imem_req drops and FIFO holds pc 0,2. Raise ready: pops 0 then 2 in order; next request addr 4.
3. L=3 with 2 outstanding, redirect with redirect_pc=16'h0100: instr_valid 0 next cycle; both late words dropped; next imem_addr 0x0100; first delivered instr_pc 0x0100.
4. gnt=0 for 5 cycles: imem_req held 1, imem_addr stable at 0x0004, no FIFO change; gnt=1 resumes normally.
5. redirect_pc=16'hFFFE: fetches FFFE then 0000; head pc_plus2 = 0000.
6. Assert reset with 2 outstanding, then 2 stray rvalids: all outputs at reset values; stray words ignored; first delivered instr_pc = RESET_PC.
